// File: rtl/gcd_pkg.sv
// Shared types and ALU opcode constants for the sequential GCD engine.
package gcd_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMP  = 3'd1,
    SUBA = 3'd2,
    SUBB = 3'd3,
    DONE = 3'd4
  } gcd_state_t;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b101;

endpackage

// File: rtl/gcd_seq.sv
// Subtractive GCD sequencer driving an external combinational ALU.
// Define GCD_ITER_CNT_EN to add the iter_cnt subtraction counter output.
module gcd_seq
  import gcd_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic [2:0]   alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_dout,
  output logic         busy,
  output logic         done,
`ifdef GCD_ITER_CNT_EN
  output logic [W-1:0] iter_cnt,
`endif
  output logic [W-1:0] result
);

  gcd_state_t state;
  gcd_state_t state_nxt;

  logic [W-1:0] ra;
  logic [W-1:0] rb;
  logic         term;
  logic         accept;

  assign term   = (ra == rb) || (ra == '0) || (rb == '0);
  assign accept = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CMP;
        end
      end
      CMP: begin
        if (term) begin
          state_nxt = DONE;
        end else if (ra > rb) begin
          state_nxt = SUBA;
        end else begin
          state_nxt = SUBB;
        end
      end
      SUBA:    state_nxt = CMP;
      SUBB:    state_nxt = CMP;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // SUBB swaps the operands so the ALU always computes larger - smaller
  always_comb begin
    busy   = (state != IDLE);
    done   = (state == DONE);
    alu_op = OP_PASS;
    alu_a  = ra;
    alu_b  = rb;
    unique case (1'b1)
      (state == SUBA): begin
        alu_op = OP_SUB;
      end
      (state == SUBB): begin
        alu_op = OP_SUB;
        alu_a  = rb;
        alu_b  = ra;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ra     <= '0;
      rb     <= '0;
      result <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            ra <= a_in;
            rb <= b_in;
          end
        end
        CMP: begin
          if (term) begin
            result <= ra | rb;
          end
        end
        SUBA:    ra <= alu_dout;
        SUBB:    rb <= alu_dout;
        default: ;
      endcase
    end
  end

`ifdef GCD_ITER_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      iter_cnt <= '0;
    end else if (accept) begin
      iter_cnt <= '0;
    end else if ((state == SUBA || state == SUBB) && iter_cnt != '1) begin
      iter_cnt <= iter_cnt + 1'b1;
    end
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule
